// File: rtl/e203_alu_dpath_pkg.sv
// Shared widths, opcode indices, FSM/shift-mode types and the non-shift
// result mux for the sequential ALU datapath.
package e203_alu_dpath_pkg;

    localparam int ALU_XLEN = 32;
    localparam int ALU_SHW  = 5;
    localparam int OP_W     = 11;

    localparam int OP_ADD  = 0;
    localparam int OP_SUB  = 1;
    localparam int OP_XOR  = 2;
    localparam int OP_SLL  = 3;
    localparam int OP_SRL  = 4;
    localparam int OP_SRA  = 5;
    localparam int OP_OR   = 6;
    localparam int OP_AND  = 7;
    localparam int OP_SLT  = 8;
    localparam int OP_SLTU = 9;
    localparam int OP_LUI  = 10;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_RESP  = 2'd2
    } state_e;

    typedef enum logic [1:0] {
        SH_SLL = 2'd0,
        SH_SRL = 2'd1,
        SH_SRA = 2'd2
    } shmode_e;

    // AND-OR mux: several set opcode bits OR their results together
    function automatic logic [ALU_XLEN-1:0] alu_mux(
        input logic [OP_W-1:0]     op,
        input logic [ALU_XLEN-1:0] a,
        input logic [ALU_XLEN-1:0] b
    );
        logic [ALU_XLEN-1:0] lt;
        logic [ALU_XLEN-1:0] ltu;
        lt  = {{(ALU_XLEN-1){1'b0}}, ($signed(a) < $signed(b))};
        ltu = {{(ALU_XLEN-1){1'b0}}, (a < b)};
        return ({ALU_XLEN{op[OP_ADD]}}  & (a + b))
             | ({ALU_XLEN{op[OP_SUB]}}  & (a - b))
             | ({ALU_XLEN{op[OP_XOR]}}  & (a ^ b))
             | ({ALU_XLEN{op[OP_OR]}}   & (a | b))
             | ({ALU_XLEN{op[OP_AND]}}  & (a & b))
             | ({ALU_XLEN{op[OP_SLT]}}  & lt)
             | ({ALU_XLEN{op[OP_SLTU]}} & ltu)
             | ({ALU_XLEN{op[OP_LUI]}}  & b);
    endfunction

endpackage

// File: rtl/e203_exu_alu_dpath_seq_shft_iter.sv
// Result register with optional 1-bit-per-cycle shifter.
// With E203_ALU_FAST_SHIFT_EN defined only the result register remains.
module e203_exu_alu_shft_iter
    import e203_alu_dpath_pkg::*;
#(
    parameter int XLEN = ALU_XLEN,
    parameter int SHW  = ALU_SHW
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            ld_i,
    input  logic [XLEN-1:0] ld_val_i,
`ifndef E203_ALU_FAST_SHIFT_EN
    input  logic            start_i,
    input  logic [SHW-1:0]  shamt_i,
    input  shmode_e         mode_i,
    input  logic            step_i,
    output logic            done_o,
`endif
    output logic [XLEN-1:0] res_o
);

    logic [XLEN-1:0] res_q, res_d;

`ifndef E203_ALU_FAST_SHIFT_EN
    logic [SHW-1:0] cnt_q, cnt_d;
    shmode_e        mode_q, mode_d;

    always_comb begin
        res_d  = res_q;
        cnt_d  = cnt_q;
        mode_d = mode_q;
        if (ld_i) begin
            res_d = ld_val_i;
            if (start_i) begin
                cnt_d  = shamt_i;
                mode_d = mode_i;
            end
        end else if (step_i) begin
            cnt_d = cnt_q - SHW'(1);
            unique case (mode_q)
                SH_SLL:  res_d = {res_q[XLEN-2:0], 1'b0};
                SH_SRL:  res_d = {1'b0, res_q[XLEN-1:1]};
                default: res_d = {res_q[XLEN-1], res_q[XLEN-1:1]};
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            res_q  <= '0;
            cnt_q  <= '0;
            mode_q <= SH_SLL;
        end else begin
            res_q  <= res_d;
            cnt_q  <= cnt_d;
            mode_q <= mode_d;
        end
    end

    assign done_o = (cnt_q == SHW'(1));
`else
    always_comb begin
        res_d = res_q;
        if (ld_i) res_d = ld_val_i;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) res_q <= '0;
        else     res_q <= res_d;
    end
`endif

    assign res_o = res_q;

endmodule

// File: rtl/e203_exu_alu_dpath_seq.sv
// Sequential shared ALU datapath: request/response handshake, FSM, result mux.
// E203_ALU_FAST_SHIFT_EN selects a single-cycle barrel shifter.
module e203_exu_alu_dpath_seq
    import e203_alu_dpath_pkg::*;
#(
    parameter int XLEN = ALU_XLEN,
    parameter int SHW  = ALU_SHW
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic [OP_W-1:0] req_op,
    input  logic [XLEN-1:0] req_op1,
    input  logic [XLEN-1:0] req_op2,
    output logic            rsp_valid,
    input  logic            rsp_ready,
    output logic [XLEN-1:0] rsp_res,
    output logic            busy
);

    state_e          state_q, state_d;
    logic            accept;
    logic            is_shift;
    logic            go_shift;
    logic [SHW-1:0]  shamt;
    logic [XLEN-1:0] ld_val;

    assign accept   = req_valid & req_ready;
    assign is_shift = |req_op[OP_SRA:OP_SLL];
    assign shamt    = req_op2[SHW-1:0];

`ifndef E203_ALU_FAST_SHIFT_EN
    shmode_e mode;
    logic    sh_done;
    logic    sh_step;

    always_comb begin
        if (req_op[OP_SLL])      mode = SH_SLL;
        else if (req_op[OP_SRL]) mode = SH_SRL;
        else                     mode = SH_SRA;
    end

    assign go_shift = is_shift & (shamt != '0);
    assign sh_step  = (state_q == ST_SHIFT);
    assign ld_val   = is_shift ? req_op1 : alu_mux(req_op, req_op1, req_op2);
`else
    logic [XLEN-1:0] bsh;

    always_comb begin
        if (req_op[OP_SLL])      bsh = req_op1 << shamt;
        else if (req_op[OP_SRL]) bsh = req_op1 >> shamt;
        else                     bsh = $signed(req_op1) >>> shamt;
    end

    assign go_shift = 1'b0;
    assign ld_val   = is_shift ? bsh : alu_mux(req_op, req_op1, req_op2);
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= ST_IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE, ST_RESP: begin
                if (accept)
                    state_d = go_shift ? ST_SHIFT : ST_RESP;
                else if ((state_q == ST_RESP) && rsp_ready)
                    state_d = ST_IDLE;
            end
`ifndef E203_ALU_FAST_SHIFT_EN
            ST_SHIFT: if (sh_done) state_d = ST_RESP;
`endif
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        req_ready = 1'b0;
        rsp_valid = 1'b0;
        busy      = 1'b1;
        unique case (state_q)
            ST_IDLE: begin
                req_ready = 1'b1;
                busy      = 1'b0;
            end
            ST_RESP: begin
                req_ready = rsp_ready;
                rsp_valid = 1'b1;
            end
            default: ;
        endcase
    end

    e203_exu_alu_shft_iter #(
        .XLEN(XLEN),
        .SHW (SHW)
    ) u_shft (
        .clk     (clk),
        .rst     (rst),
        .ld_i    (accept),
        .ld_val_i(ld_val),
`ifndef E203_ALU_FAST_SHIFT_EN
        .start_i (go_shift),
        .shamt_i (shamt),
        .mode_i  (mode),
        .step_i  (sh_step),
        .done_o  (sh_done),
`endif
        .res_o   (rsp_res)
    );

endmodule

// File: tb/tb_e203_exu_alu_dpath_seq.sv
// Directed plus random checks of the sequential ALU datapath against
// an arithmetic reference model.
module tb_e203_exu_alu_dpath_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic [10:0] req_op;
    logic [31:0] req_op1;
    logic [31:0] req_op2;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_res;
    logic        busy;

    int checks   = 0;
    int failures = 0;

    e203_exu_alu_dpath_seq dut (
        .clk      (clk),
        .rst      (rst),
        .req_valid(req_valid),
        .req_ready(req_ready),
        .req_op   (req_op),
        .req_op1  (req_op1),
        .req_op2  (req_op2),
        .rsp_valid(rsp_valid),
        .rsp_ready(rsp_ready),
        .rsp_res  (rsp_res),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] ref_alu(input logic [10:0] op,
                                            input logic [31:0] a,
                                            input logic [31:0] b);
        logic [31:0] r;
        int sh;
        sh = int'(b[4:0]);
        if (op[3]) return a << sh;
        if (op[4]) return a >> sh;
        if (op[5]) return 32'($signed(a) >>> sh);
        r = 32'h0;
        if (op[0])  r |= a + b;
        if (op[1])  r |= a - b;
        if (op[2])  r |= a ^ b;
        if (op[6])  r |= a | b;
        if (op[7])  r |= a & b;
        if (op[8])  r |= ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
        if (op[9])  r |= (a < b) ? 32'd1 : 32'd0;
        if (op[10]) r |= b;
        return r;
    endfunction

    function automatic int ref_lat(input logic [10:0] op,
                                   input logic [31:0] b);
`ifdef E203_ALU_FAST_SHIFT_EN
        return 1;
`else
        if (op[5:3] != 3'b000) return 1 + int'(b[4:0]);
        return 1;
`endif
    endfunction

    task automatic do_op(input string tag, input logic [10:0] op,
                         input logic [31:0] a, input logic [31:0] b);
        logic [31:0] exp;
        int lat;
        exp = ref_alu(op, a, b);
        req_valid = 1'b1;
        req_op    = op;
        req_op1   = a;
        req_op2   = b;
        rsp_ready = 1'b1;
        #1;
        check({tag, ".rdy"}, 32'(req_ready), 32'd1);
        step();
        req_valid = 1'b0;
        lat = 1;
        while (!rsp_valid && lat < 40) begin
            step();
            lat++;
        end
        check({tag, ".lat"}, 32'(lat), 32'(ref_lat(op, b)));
        check({tag, ".res"}, rsp_res, exp);
        step();
        check({tag, ".idle"}, 32'(busy), 32'd0);
    endtask

    function automatic logic [10:0] rand_nonshift_op();
        int idx[8] = '{0, 1, 2, 6, 7, 8, 9, 10};
        int m;
        logic [10:0] op;
        m = int'($urandom_range(0, 9));
        op = 11'h0;
        if (m == 0) op = 11'h0;
        else if (m == 1) op = 11'($urandom) & 11'b111_1100_0111;
        else op[idx[$urandom_range(0, 7)]] = 1'b1;
        return op;
    endfunction

    initial begin
        logic [31:0] a, b, exp_x, exp_a;
        logic [10:0] op;

        rst       = 1'b1;
        req_valid = 1'b0;
        req_op    = 11'h0;
        req_op1   = 32'h0;
        req_op2   = 32'h0;
        rsp_ready = 1'b1;
        #2;
        check("rst.req_ready", 32'(req_ready), 32'd1);
        check("rst.rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst.rsp_res", rsp_res, 32'h0);
        check("rst.busy", 32'(busy), 32'd0);
        step();
        step();
        rst = 1'b0;
        step();

        do_op("add", 11'h001, 32'h0000_0005, 32'hFFFF_FFFF);
        do_op("slt", 11'h100, 32'h8000_0000, 32'h0000_0001);
        do_op("sltu", 11'h200, 32'h8000_0000, 32'h0000_0001);
        do_op("sub", 11'h002, 32'h0, 32'h1);
        do_op("sra31", 11'h020, 32'h8000_0000, 32'd31);
        do_op("sll0", 11'h008, 32'hDEAD_BEEF, 32'h0);
        do_op("lui", 11'h400, 32'h1234_5678, 32'hABCD_E000);
        do_op("op0", 11'h000, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        do_op("multi_sh", 11'h031, 32'hF000_000F, 32'd4);

        for (int i = 0; i < 6; i++) begin
            op = 11'h0;
            op[3 + $urandom_range(0, 2)] = 1'b1;
            do_op("rnd_shift", op, $urandom, $urandom);
        end

        // backpressure with a queued add
        a = 32'h1357_9BDF;
        b = 32'h0F0F_00FF;
        exp_x = ref_alu(11'h004, a, b);
        exp_a = ref_alu(11'h001, 32'h10, 32'h22);
        req_valid = 1'b1;
        req_op    = 11'h004;
        req_op1   = a;
        req_op2   = b;
        rsp_ready = 1'b0;
        step();
        req_op  = 11'h001;
        req_op1 = 32'h10;
        req_op2 = 32'h22;
        for (int i = 0; i < 5; i++) begin
            #1;
            check("bp.valid", 32'(rsp_valid), 32'd1);
            check("bp.res", rsp_res, exp_x);
            check("bp.req_ready", 32'(req_ready), 32'd0);
            step();
        end
        rsp_ready = 1'b1;
        #1;
        check("bp.release_ready", 32'(req_ready), 32'd1);
        step();
        req_valid = 1'b0;
        check("bp.next_valid", 32'(rsp_valid), 32'd1);
        check("bp.next_res", rsp_res, exp_a);
        step();
        check("bp.idle", 32'(busy), 32'd0);

        // reset in flight
        req_valid = 1'b1;
        req_op    = 11'h008;
        req_op1   = 32'h1;
        req_op2   = 32'd20;
        rsp_ready = 1'b0;
        step();
        req_valid = 1'b0;
        for (int i = 0; i < 10; i++) step();
        check("mid.busy", 32'(busy), 32'd1);
        rst = 1'b1;
        #1;
        check("mid.rsp_valid", 32'(rsp_valid), 32'd0);
        check("mid.busy0", 32'(busy), 32'd0);
        check("mid.rsp_res", rsp_res, 32'h0);
        check("mid.req_ready", 32'(req_ready), 32'd1);
        step();
        rst = 1'b0;
        step();
        do_op("or_after_rst", 11'h040, 32'h0F, 32'hF0);
        check("or_after_rst.const", rsp_res, 32'hFF);

        // streaming non-shift ops
        rsp_ready = 1'b1;
        for (int i = 0; i < 100; i++) begin
            op = rand_nonshift_op();
            a  = ($urandom_range(0, 7) == 0) ? 32'h8000_0000 : $urandom;
            b  = ($urandom_range(0, 7) == 0) ? 32'h7FFF_FFFF : $urandom;
            req_valid = 1'b1;
            req_op    = op;
            req_op1   = a;
            req_op2   = b;
            #1;
            check("str.ready", 32'(req_ready), 32'd1);
            step();
            check("str.valid", 32'(rsp_valid), 32'd1);
            check("str.res", rsp_res, ref_alu(op, a, b));
        end
        req_valid = 1'b0;
        step();
        check("str.drain", 32'(rsp_valid), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule
